// File: rtl/tx_cipher_buffer.sv
// FIFO staging buffer between the formatMPDU byte stream and the RC4 PRN engine.
// Issues one registered strobe per word, tags the frame end word for the ICV drain.
module tx_cipher_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  macCoreClk,
    input  logic                  macCoreClkRst,
    input  logic [DATA_WIDTH-1:0] txPlainData,
    input  logic                  txPlainDataValid,
    input  logic                  txPlainDataEnd,
    output logic                  txBufferNextFull,
    input  logic                  txCsIsIdle,
    input  logic [2:0]            cipherType,
    input  logic                  initDone_p,
    input  logic                  prnOutValid_p,
    input  logic                  txFcsBusy,
    output logic [DATA_WIDTH-1:0] txPlainDataOut,
    output logic                  prnStrobe_p,
    output logic                  icvEnable_p_tx,
    output logic                  icvSDrain_p,
    output logic [PTR_W:0]        bufLevel,
    output logic                  bufOverflow
);

    localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ALMOST = (PTR_W+1)'(DEPTH-1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [DATA_WIDTH-1:0] dataMem [DEPTH];
    logic [DEPTH-1:0]      endMem;
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [PTR_W:0]        count;
    logic                  bufferEn;
    logic                  engineBusy;

    logic enableReq;
    logic issue;
    logic push;
    logic overflowHit;

    assign enableReq = initDone_p && (cipherType == 3'd1 || cipherType == 3'd2);

    // prnOutValid_p during an FCS stall clears engineBusy, so the pending
    // issue simply fires once txFcsBusy drops.
    assign issue = bufferEn && (count != '0) && !txFcsBusy && (!engineBusy || prnOutValid_p);

    // A full buffer still takes a word when the head leaves in the same cycle.
    assign push        = bufferEn && txPlainDataValid && ((count != CNT_FULL) || issue);
    assign overflowHit = bufferEn && txPlainDataValid && (count == CNT_FULL) && !issue;

    assign txBufferNextFull = bufferEn &&
                              ((count == CNT_FULL) ||
                               ((count == CNT_ALMOST) && txPlainDataValid && !issue));

    assign icvEnable_p_tx = bufferEn ? prnStrobe_p : txPlainDataValid;
    assign bufLevel       = count;

    always_ff @(posedge macCoreClk) begin
        if (push)
            dataMem[wrPtr] <= txPlainData;
    end

    always_ff @(posedge macCoreClk) begin
        if (macCoreClkRst) begin
            wrPtr          <= '0;
            rdPtr          <= '0;
            count          <= '0;
            endMem         <= '0;
            txPlainDataOut <= '0;
            prnStrobe_p    <= 1'b0;
            icvSDrain_p    <= 1'b0;
            bufOverflow    <= 1'b0;
            bufferEn       <= 1'b0;
            engineBusy     <= 1'b0;
        end else if (txCsIsIdle || enableReq) begin
            // idle wins over a coincident init pulse
            bufferEn    <= !txCsIsIdle;
            wrPtr       <= '0;
            rdPtr       <= '0;
            count       <= '0;
            engineBusy  <= 1'b0;
            prnStrobe_p <= 1'b0;
            icvSDrain_p <= 1'b0;
            bufOverflow <= 1'b0;
        end else begin
            prnStrobe_p <= issue;
            icvSDrain_p <= issue && endMem[rdPtr];
            if (issue) begin
                txPlainDataOut <= dataMem[rdPtr];
                rdPtr          <= rdPtr + PTR_ONE;
            end
            if (push) begin
                endMem[wrPtr] <= txPlainDataEnd;
                wrPtr         <= wrPtr + PTR_ONE;
            end
            if (overflowHit)
                bufOverflow <= 1'b1;
            if (push && !issue)
                count <= count + CNT_ONE;
            else if (issue && !push)
                count <= count - CNT_ONE;
            if (issue)
                engineBusy <= 1'b1;
            else if (prnOutValid_p)
                engineBusy <= 1'b0;
        end
    end

endmodule
